// File: rtl/pipe_ctrl.sv
// pipe_ctrl: in-order pipeline controller.
// Generates the stage enables, pipeline-register flushes and fetch redirect
// from the hazard, redirect, memory-wait and halt inputs, and counts stall
// cycles. A small FSM sequences refill masking, memory waits, the halt drain
// and the halted state.
// Optional feature: define PIPE_CTRL_STEP_EN to let step_req single-step a
// halted pipeline (HALT -> STEP -> DRAIN -> HALT). Without it step_req is
// accepted on the port and ignored.
//
// Handshake note: there is no valid/ready pairing here. Every output is a
// per-cycle level; redirect_valid qualifies redirect_pc for exactly the
// cycle it is high, and the fetch unit must act on it in that cycle.

module pipe_ctrl #(
    parameter int DRAIN_CYCLES  = 3,
    parameter int REFILL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    input  logic        mem_busy,
    input  logic        halt_req,
    input  logic        step_req,
    output logic        if_en,
    output logic        id_en,
    output logic        ex_en,
    output logic        mem_en,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [2:0]  dbg_state
);

    // FSM encoding
    localparam logic [2:0] ST_RUN      = 3'd0;
    localparam logic [2:0] ST_REFILL   = 3'd1;
    localparam logic [2:0] ST_MEM_WAIT = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;
`ifdef PIPE_CTRL_STEP_EN
    localparam logic [2:0] ST_STEP     = 3'd5;
`endif

    // One shared down-counter serves both REFILL and DRAIN; size it for
    // the larger of the two reload values.
    localparam int CNT_MAX = (DRAIN_CYCLES > REFILL_CYCLES) ? DRAIN_CYCLES : REFILL_CYCLES;
    localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES - 1);
    localparam logic [CW-1:0] REFILL_LOAD = CW'(REFILL_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sav_state_q, sav_state_d;
    logic [CW-1:0] sav_cnt_q, sav_cnt_d;
    logic [15:0]   stall_q, stall_d;
    logic          halted_q, halted_d;

    logic          load_use;
    logic          take_redirect;
    logic [2:0]    eff_state;
    logic [CW-1:0] eff_cnt;

`ifndef PIPE_CTRL_STEP_EN
    logic unused_step_req;
    assign unused_step_req = step_req;
`endif

    // Load-use: the instruction in ID reads the register a load in EX is
    // about to write. x0 is hardwired, so it never creates a dependency.
    assign load_use = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign take_redirect = ex_valid & ex_redirect;

    // Leaving MEM_WAIT resumes the saved state in the same cycle, so the
    // event logic always works on the "effective" state and counter.
    assign eff_state = (state_q == ST_MEM_WAIT) ? sav_state_q : state_q;
    assign eff_cnt   = (state_q == ST_MEM_WAIT) ? sav_cnt_q   : cnt_q;

    // Next-state logic and the combinational enable/flush/redirect outputs.
    always_comb begin
        if_en          = 1'b0;
        id_en          = 1'b0;
        ex_en          = 1'b0;
        mem_en         = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        sav_state_d    = sav_state_q;
        sav_cnt_d      = sav_cnt_q;

        if (rst) begin
            // Freeze everything and squash both pipeline registers.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
            sav_state_d = ST_RUN;
            sav_cnt_d   = '0;
        end else if (state_q == ST_HALT) begin
            // Halted: pipeline frozen, memory waits irrelevant.
            state_d = halt_req ? ST_HALT : ST_RUN;
`ifdef PIPE_CTRL_STEP_EN
            if (step_req) begin
                state_d = ST_STEP;
            end
`endif
        end else if (mem_busy) begin
            // Memory wait freezes every stage; any redirect in EX stays
            // there and is presented again once the wait ends.
            state_d     = ST_MEM_WAIT;
            sav_state_d = eff_state;
            sav_cnt_d   = eff_cnt;
        end else begin
            state_d = eff_state;
            cnt_d   = eff_cnt;
            case (eff_state)
                ST_RUN: begin
                    if_en  = 1'b1;
                    id_en  = 1'b1;
                    ex_en  = 1'b1;
                    mem_en = 1'b1;
                    if (take_redirect) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                        state_d        = ST_REFILL;
                        cnt_d          = REFILL_LOAD;
                    end else if (load_use) begin
                        // Hold IF and ID; the ID/EX register takes a bubble
                        // while the load moves on.
                        if_en = 1'b0;
                        id_en = 1'b0;
                    end else if (halt_req) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
                ST_REFILL: begin
                    // Freshly fetched path: hazards cannot involve the
                    // flushed instructions, so detection is masked.
                    if_en  = 1'b1;
                    id_en  = 1'b1;
                    ex_en  = 1'b1;
                    mem_en = 1'b1;
                    if (take_redirect) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                        cnt_d          = REFILL_LOAD;
                    end else if (eff_cnt == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = eff_cnt - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Stop fetching; let EX/MEM/WB empty out.
                    ex_en  = 1'b1;
                    mem_en = 1'b1;
                    if (take_redirect) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                    end
                    if (eff_cnt == '0) begin
                        state_d = ST_HALT;
                    end else begin
                        cnt_d = eff_cnt - 1'b1;
                    end
                end
`ifdef PIPE_CTRL_STEP_EN
                ST_STEP: begin
                    // One cycle of full advance, then drain back to HALT.
                    if_en  = 1'b1;
                    id_en  = 1'b1;
                    ex_en  = 1'b1;
                    mem_en = 1'b1;
                    if (take_redirect) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = ex_target;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                    end
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
`endif
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Stall counter and halted flag next values.
    always_comb begin
        stall_d = stall_q;
        if (!if_en && (state_q != ST_HALT) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        halted_d = (state_d == ST_HALT);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            sav_state_q <= ST_RUN;
            sav_cnt_q   <= '0;
            stall_q     <= 16'h0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sav_state_q <= sav_state_d;
            sav_cnt_q   <= sav_cnt_d;
            stall_q     <= stall_d;
            halted_q    <= halted_d;
        end
    end

    assign stall_cnt = stall_q;
    assign halted    = halted_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed bench for pipe_ctrl with default parameters.
// Each vector is one clock cycle: the driver sets inputs just after a rising
// edge and queues the outputs it expects for that cycle; a monitor on the
// falling edge pops and compares.

module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        ex_valid;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        mem_busy;
  logic        halt_req;
  logic        step_req;
  logic        if_en;
  logic        id_en;
  logic        ex_en;
  logic        mem_en;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [2:0]  dbg_state;

  localparam logic [3:0] EN_ALL   = 4'b1111;
  localparam logic [3:0] EN_STALL = 4'b0011;
  localparam logic [3:0] EN_NONE  = 4'b0000;

  logic [55:0] exp_q[$];
  string       name_q[$];
  int          n_vec;
  int          n_miss;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_rd          (ex_rd),
    .ex_redirect    (ex_redirect),
    .ex_target      (ex_target),
    .mem_busy       (mem_busy),
    .halt_req       (halt_req),
    .step_req       (step_req),
    .if_en          (if_en),
    .id_en          (id_en),
    .ex_en          (ex_en),
    .mem_en         (mem_en),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .stall_cnt      (stall_cnt),
    .dbg_state      (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d expected cycles still queued", exp_q.size());
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle();
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_uses_rs1 = 1'b0;
    id_uses_rs2 = 1'b0;
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_rd       = 5'd0;
    ex_redirect = 1'b0;
    ex_target   = 32'h0;
    mem_busy    = 1'b0;
    halt_req    = 1'b0;
    step_req    = 1'b0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = rd;
  endtask

  task automatic id_src(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
    id_rs1      = r1;
    id_uses_rs1 = u1;
    id_rs2      = r2;
    id_uses_rs2 = u2;
  endtask

  task automatic ex_br(input logic [31:0] t);
    ex_valid    = 1'b1;
    ex_redirect = 1'b1;
    ex_target   = t;
  endtask

  // Queue the expected outputs for the current cycle, then advance.
  task automatic vec(input string nm, input logic [3:0] en, input logic [1:0] fl,
                     input logic rv, input logic [31:0] pc, input logic h, input logic [15:0] sc);
    exp_q.push_back({en, fl, rv, pc, h, sc});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [55:0] e;
    logic [55:0] a;
    string       nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {if_en, id_en, ex_en, mem_en, flush_if_id, flush_id_ex,
            redirect_valid, redirect_pc, halted, stall_cnt};
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL %s: got en=%b fl=%b rv=%b pc=%h halted=%b stall=%0d, expected en=%b fl=%b rv=%b pc=%h halted=%b stall=%0d",
                 nm, a[55:52], a[51:50], a[49], a[48:17], a[16], a[15:0],
                 e[55:52], e[51:50], e[49], e[48:17], e[16], e[15:0]);
      end
    end
  end

  // directed stimulus
  initial begin
    n_vec  = 0;
    n_miss = 0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;

    // reset cycle outputs
    vec("reset_cycle", EN_NONE, 2'b11, 1'b0, 32'h0, 1'b0, 16'd0);
    rst = 1'b0;
    idle();
    vec("run_idle", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0);

    // load-use hazards
    idle(); ex_load(5'd5); id_src(5'd5, 1'b1, 5'd1, 1'b1);
    vec("lu_rs1", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0);
    idle(); ex_valid = 1'b1; ex_rd = 5'd6; id_src(5'd5, 1'b1, 5'd1, 1'b1);
    vec("lu_release", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd1);
    idle(); ex_load(5'd0); id_src(5'd0, 1'b1, 5'd0, 1'b0);
    vec("lu_x0", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd1);
    idle(); ex_load(5'd5); id_src(5'd3, 1'b1, 5'd5, 1'b0);
    vec("lu_rs2_unused", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd1);
    idle(); ex_load(5'd7); id_src(5'd2, 1'b1, 5'd7, 1'b1);
    vec("lu_rs2", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd1);
    idle();
    vec("after_rs2", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd2);

    // redirect and refill masking
    idle(); ex_redirect = 1'b1; ex_target = 32'h40;
    vec("redir_invalid", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd2);
    idle(); ex_br(32'h0000_0100);
    vec("redirect", EN_ALL, 2'b11, 1'b1, 32'h0000_0100, 1'b0, 16'd2);
    idle(); ex_load(5'd5); id_src(5'd5, 1'b1, 5'd0, 1'b0);
    vec("refill_mask1", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd2);
    vec("refill_mask2", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd2);
    vec("refill_done_hazard", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd2);
    idle();
    vec("post_refill", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd3);

    // memory wait deferring a redirect
    for (int i = 0; i < 3; i++) begin
      idle(); ex_br(32'h0000_0200); mem_busy = 1'b1;
      vec("mem_wait", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b0, 16'(3 + i));
    end
    idle(); ex_br(32'h0000_0200);
    vec("deferred_redirect", EN_ALL, 2'b11, 1'b1, 32'h0000_0200, 1'b0, 16'd6);
    idle(); mem_busy = 1'b1; ex_load(5'd5); id_src(5'd5, 1'b1, 5'd0, 1'b0);
    vec("busy_in_refill", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b0, 16'd6);
    idle(); ex_load(5'd5); id_src(5'd5, 1'b1, 5'd0, 1'b0);
    vec("resume_refill_mask", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd7);
    vec("resume_refill_last", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd7);
    vec("resume_run_hazard", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd7);
    idle();
    vec("run_again", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd8);

    // halt drain, request dropped mid-drain, redirect in drain
    idle(); halt_req = 1'b1;
    vec("halt_accept", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd8);
    idle();
    vec("drain1", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd8);
    idle(); ex_br(32'h0000_0300);
    vec("drain2_redirect", EN_STALL, 2'b11, 1'b1, 32'h0000_0300, 1'b0, 16'd9);
    idle();
    vec("drain3", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd10);
    idle(); halt_req = 1'b1;
    vec("halted", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b1, 16'd11);
    idle(); halt_req = 1'b1; mem_busy = 1'b1;
`ifndef PIPE_CTRL_STEP_EN
    step_req = 1'b1;
`endif
    vec("halt_hold", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b1, 16'd11);
    idle();
    vec("halt_release", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b1, 16'd11);
    vec("resume_run", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd11);

    // priority: redirect > load-use > halt_req
    idle(); ex_br(32'h0000_0400); ex_is_load = 1'b1; ex_rd = 5'd5;
    id_src(5'd5, 1'b1, 5'd0, 1'b0); halt_req = 1'b1;
    vec("prio_redirect", EN_ALL, 2'b11, 1'b1, 32'h0000_0400, 1'b0, 16'd11);
    idle(); halt_req = 1'b1;
    vec("refill_ignores_halt1", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd11);
    vec("refill_ignores_halt2", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd11);
    idle(); halt_req = 1'b1; ex_load(5'd5); id_src(5'd5, 1'b1, 5'd0, 1'b0);
    vec("prio_hazard_over_halt", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd11);
    idle(); halt_req = 1'b1;
    vec("halt_accept2", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd12);
    idle();
    vec("drain_a", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd12);

    // reset in the middle of a drain
    idle(); rst = 1'b1;
    vec("rst_mid_drain", EN_NONE, 2'b11, 1'b0, 32'h0, 1'b0, 16'd13);
    rst = 1'b0; idle();
    vec("after_rst", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0);
    idle(); step_req = 1'b1;
    vec("step_outside_halt", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0);

`ifdef PIPE_CTRL_STEP_EN
    // single step from HALT
    idle(); halt_req = 1'b1;
    vec("s_halt_accept", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      vec("s_drain", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'(i));
    end
    vec("s_halted", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b1, 16'd3);
    step_req = 1'b1;
    vec("s_step_req", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b1, 16'd3);
    step_req = 1'b0;
    vec("s_step", EN_ALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      vec("s_step_drain", EN_STALL, 2'b00, 1'b0, 32'h0, 1'b0, 16'(3 + i));
    end
    vec("s_rehalted", EN_NONE, 2'b00, 1'b0, 32'h0, 1'b1, 16'd6);
`endif

    // let the monitor consume what is queued, bounded
    idle();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain_queue: %0d expected cycles never checked, required 0", exp_q.size());
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, cycles to empty EX/MEM/WB before HALT.
REQ-002 Parameter REFILL_CYCLES, default 2, cycles after a redirect during which hazard detection is masked.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID; id_uses_rs1, id_uses_rs2  in  1 each  source is read.
REQ-006 ex_valid, ex_is_load  in  1 each  EX holds a valid instruction, which is a load; ex_rd  in  5  its destination.
REQ-007 ex_redirect  in  1  EX-resolved next PC differs from the fetched path; ex_target  in  32  resolved PC (already aligned).
REQ-008 mem_busy  in  1  data memory wait; halt_req  in  1  level halt request; step_req  in  1  single-step pulse (REQ-027 only).
REQ-009 if_en, id_en, ex_en, mem_en  out  1 each  stage enables, driven to the stage en inputs.
REQ-010 flush_if_id, flush_id_ex  out  1 each  invalidate the named pipeline register on the next edge.
REQ-011 redirect_valid  out  1; redirect_pc  out  32  fetch redirect, valid for one cycle.
REQ-012 halted  out  1  pipeline empty and frozen; stall_cnt  out  16  stall-cycle counter.

Function
REQ-013 States: RUN, REFILL, MEM_WAIT, DRAIN, HALT (plus STEP with REQ-027); enables/flush/redirect are combinational from state and inputs, all else registered.
REQ-014 Priority within one cycle: rst > mem_busy > redirect > load-use > halt_req.
REQ-015 Load-use hazard = ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)); x0 never hazards.
REQ-016 RUN, no event: all enables 1, flushes 0, redirect_valid 0.
REQ-017 RUN with hazard: if_en=0, id_en=0 (bubble into ID/EX), ex_en=1, mem_en=1, same cycle; stay RUN; one bubble per hazard since the load leaves EX.
REQ-018 RUN or REFILL with ex_valid & ex_redirect: redirect_valid=1, redirect_pc=ex_target, flush_if_id=flush_id_ex=1, all enables 1, same cycle; next state REFILL, refill counter loaded REFILL_CYCLES-1.
REQ-019 REFILL: enables as RUN, load-use masked, redirect honoured (REQ-018, counter reloads); counter decrements, RUN after count 0 cycle.
REQ-020 Any state except HALT with mem_busy=1: all enables 0, flushes 0, redirect_valid 0; enter MEM_WAIT, save current state and counter; pending redirect deferred (EX frozen, re-presented).
REQ-021 MEM_WAIT with mem_busy=0: return to saved state with saved counter, re-evaluate events that cycle.
REQ-022 RUN with halt_req and no higher event: enter DRAIN, counter DRAIN_CYCLES-1; DRAIN: if_en=0, id_en=0, ex_en=1, mem_en=1; redirect in DRAIN still flushes/redirects but stays DRAIN.
REQ-023 DRAIN count 0 -> HALT: all enables 0, halted=1; halt_req=0 in HALT -> RUN next cycle; halt_req dropped during DRAIN still completes the drain.
REQ-024 stall_cnt increments, saturating at 0xFFFF, each cycle with if_en=0 and state not HALT.

Reset
REQ-025 rst in any state: next state RUN, counters 0, saved state RUN, stall_cnt 0, halted 0; in the rst cycle all enables 0, flushes 1, redirect_valid 0, redirect_pc 0.
REQ-026 First cycle after rst deasserts: RUN outputs per REQ-016.

Configuration
REQ-027 PIPE_CTRL_STEP_EN defined: step_req in HALT -> STEP one cycle (all enables 1, halted 0), then DRAIN with counter DRAIN_CYCLES-1, then HALT; step_req outside HALT ignored.
REQ-028 PIPE_CTRL_STEP_EN undefined: step_req port present and ignored, STEP state absent.

Verification
REQ-029 lw x5 in EX, ID add x6,x5,x1 (rs1=5) -> one cycle if_en=0,id_en=0,ex_en=1; next cycle all 1; stall_cnt=1.
REQ-030 Same with ex_rd=0, id_rs1=0 -> no stall; lw in EX with ID rs2=5, id_uses_rs2=0 -> no stall.
REQ-031 ex_redirect, ex_target=0x0000_0100 -> redirect_valid=1, redirect_pc=0x100, both flushes 1 for 1 cycle; hazard ignored next 2 cycles.
REQ-032 mem_busy held 3 cycles concurrent with ex_redirect -> enables 0 for 3 cycles, redirect_valid at cycle 4; stall_cnt +3.
REQ-033 halt_req high -> 3 DRAIN cycles (if_en=0,ex_en=1), halted=1 on cycle 4; rst asserted mid-DRAIN -> RUN, stall_cnt 0.
REQ-034 With PIPE_CTRL_STEP_EN, step_req in HALT -> 1 cycle all en=1, 3 DRAIN cycles, halted=1 again.
